// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
//   state_t       : fetch FSM states
//   ALIGN_MASK    : clears the byte offset of a PC to form a word address
//   fetch_entry_t : one buffered instruction tagged with its aligned PC
package ifetch_pkg;

    localparam int unsigned IF_ADDR_W = 32;
    localparam int unsigned IF_DATA_W = 32;

    localparam logic [IF_ADDR_W-1:0] ALIGN_MASK = ~IF_ADDR_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding tagged instructions.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared too)
//   clear      : synchronous flush; wins over push and pop
//   push/wdata : write one entry (caller guarantees a free slot)
//   pop        : retire the head (caller guarantees non-empty)
//   count      : number of valid entries
//   head       : entry at the read pointer
module ifetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: issues word reads at the current PC over a req/gnt/rvalid
// handshake, tags returned words with their PC, and buffers them for decode.
// Ports:
//   pc_i / pc_en_o         : current PC in; pulse when the fetch at pc_i is accepted
//   flush_i                : redirect, drops buffered and in-flight instructions
//   imem_req_o/addr_o      : memory request and word-aligned address
//   imem_gnt_i/rvalid_i/rdata_i : memory accept and read return
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i : decode-side handshake
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W = IF_ADDR_W,
    parameter int unsigned DATA_W = IF_DATA_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_en_o,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    state_t            state;
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] pc_aligned;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign pc_aligned = pc_i & ADDR_W'(ALIGN_MASK);

    // Request and address are driven straight from the state register so the
    // address follows pc_i while the request waits for a grant.
    assign imem_req_o  = (state == REQ);
    assign imem_addr_o = imem_req_o ? pc_aligned : '0;
    assign pc_en_o     = imem_req_o && imem_gnt_i && !flush_i;

    assign push          = (state == WAIT) && imem_rvalid_i && !flush_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_valid_o = (count != '0);
    assign count_after   = count + CNT_W'(push) - CNT_W'(pop);

    assign push_entry = '{pc: IF_ADDR_W'(req_pc), instr: IF_DATA_W'(imem_rdata_i)};

    // Fetch control; only one request is ever outstanding and a request is only
    // issued with a free slot, so the FIFO can never overflow on a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((count < CNT_W'(DEPTH)) && !flush_i) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (imem_gnt_i) begin
                        if (flush_i) begin
                            state <= DROP;
                        end else begin
                            req_pc <= pc_aligned;
                            state  <= WAIT;
                        end
                    end else if (flush_i) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state <= (!flush_i && (count_after < CNT_W'(DEPTH))) ? REQ : IDLE;
                    end else if (flush_i) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush_i),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .count (count),
        .head  (head_entry)
    );

    assign instr_o    = DATA_W'(head_entry.instr);
    assign instr_pc_o = ADDR_W'(head_entry.pc);

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: directed scenarios plus randomized traffic against
// a queue-based model of delivered instructions and a simple memory responder.
module tb_ifetch_buffer;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] pc_i;
    logic              pc_en_o;
    logic              flush_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DATA_W-1:0] imem_rdata_i;
    logic              instr_valid_o;
    logic [DATA_W-1:0] instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_ready_i;

    ifetch_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .pc_en_o       (pc_en_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pc_en;

    // Stimulus knobs for the next cycle.
    logic        k_gnt, k_ready, k_flush, k_fixed;
    int          k_lat;
    logic [31:0] k_data, k_target;

    // Memory responder and upstream PC register.
    bit          pend, pend_killed, pend_stale;
    int          wait_cnt;
    logic [31:0] pend_pc, pend_data;
    logic [31:0] pc_reg;

    // Outputs sampled in the current cycle.
    logic        s_req, s_pc_en, s_valid, s_rvalid;
    logic [31:0] s_addr, s_instr, s_ipc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, update model at posedge.
    task automatic cycle();
        logic push, grant;
        exp_t e;
        @(negedge clk);
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (pend) begin
            if (wait_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = pend_data;
            end else begin
                wait_cnt--;
            end
        end
        pc_i          = pc_reg;
        imem_gnt_i    = k_gnt;
        instr_ready_i = k_ready;
        flush_i       = k_flush;
        #1;
        s_req    = imem_req_o;
        s_pc_en  = pc_en_o;
        s_valid  = instr_valid_o;
        s_addr   = imem_addr_o;
        s_instr  = instr_o;
        s_ipc    = instr_pc_o;
        s_rvalid = imem_rvalid_i;
        check("valid", 64'(s_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("instr", 64'(s_instr), 64'(q[0].instr));
            check("instr_pc", 64'(s_ipc), 64'(q[0].pc));
        end
        if (s_req) begin
            check("addr", 64'(s_addr), 64'(pc_reg & 32'hFFFF_FFFC));
            check("req_ok", 64'((pend && !pend_stale) || (q.size() >= DEPTH)), 64'(0));
        end
        check("pc_en", 64'(s_pc_en), 64'(s_req && k_gnt && !k_flush));
        if (s_pc_en) n_pc_en++;

        @(posedge clk);
        push  = 1'b0;
        e     = '{pend_pc, pend_data};
        if (s_rvalid) begin
            push = !pend_killed && !k_flush;
            pend = 1'b0;
        end
        grant = s_req && k_gnt;
        if (k_flush) begin
            q.delete();
        end else begin
            if (s_valid && k_ready) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        if (grant) begin
            pend        = 1'b1;
            pend_killed = k_flush;
            pend_stale  = 1'b0;
            pend_pc     = pc_reg & 32'hFFFF_FFFC;
            pend_data   = k_fixed ? k_data : $urandom;
            wait_cnt    = k_lat - 1;
        end else if (pend && k_flush) begin
            pend_killed = 1'b1;
        end
        if (s_pc_en) pc_reg += 32'd4;
        if (k_flush) pc_reg = k_target;
    endtask

    // Hold reset across two edges, check reset outputs, release just after a negedge.
    task automatic do_reset();
        rst_n         = 1'b0;
        k_gnt         = 1'b0;
        k_ready       = 1'b0;
        k_flush       = 1'b0;
        k_fixed       = 1'b0;
        k_lat         = 1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        flush_i       = 1'b0;
        instr_ready_i = 1'b0;
        pc_i          = pc_reg;
        q.delete();
        pend          = 1'b0;
        pend_killed   = 1'b0;
        pend_stale    = 1'b0;
        n_pc_en       = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 64'(imem_req_o), 64'(0));
        check("rst_addr", 64'(imem_addr_o), 64'(0));
        check("rst_pc_en", 64'(pc_en_o), 64'(0));
        check("rst_valid", 64'(instr_valid_o), 64'(0));
        check("rst_instr", 64'(instr_o), 64'(0));
        check("rst_instr_pc", 64'(instr_pc_o), 64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // First fetch after reset, fixed latencies.
        pc_reg = 32'h40;
        do_reset();
        k_gnt = 1'b1; k_ready = 1'b1; k_lat = 1; k_fixed = 1'b1; k_data = 32'h2008_0005;
        cycle();
        cycle();
        check("t1_pc_en_once", 64'(n_pc_en), 64'(1));
        cycle();
        check("t1_valid", 64'(s_valid), 64'(1));
        check("t1_instr", 64'(s_instr), 64'h2008_0005);
        check("t1_pc", 64'(s_ipc), 64'h40);

        // Decode stalled: fetch stops when two instructions are buffered.
        pc_reg = 32'h0;
        do_reset();
        k_gnt = 1'b1; k_ready = 1'b0; k_lat = 1;
        repeat (9) cycle();
        check("t2_fetches", 64'(n_pc_en), 64'(2));
        check("t2_req_full", 64'(s_req), 64'(0));
        k_ready = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            if (s_req) begin
                found = 1'b1;
                check("t2_resume_addr", 64'(s_addr), 64'h8);
            end
        end
        check("t2_resume", 64'(found), 64'(1));
        repeat (6) cycle();

        // Unaligned PC.
        pc_reg = 32'h13;
        do_reset();
        k_gnt = 1'b0; k_ready = 1'b1; k_lat = 2;
        cycle();
        check("t3_req", 64'(s_req), 64'(1));
        check("t3_addr", 64'(s_addr), 64'h10);
        k_gnt = 1'b1;
        cycle();
        k_gnt = 1'b0;
        for (int i = 0; i < 6 && !s_valid; i++) cycle();
        check("t3_seen", 64'(s_valid), 64'(1));
        check("t3_instr_pc", 64'(s_ipc), 64'h10);

        // Flush while waiting for data; late data is dropped.
        pc_reg = 32'h100;
        do_reset();
        k_gnt = 1'b1; k_ready = 1'b0; k_lat = 4; k_fixed = 1'b1; k_data = 32'hDEAD_BEEF;
        k_target = 32'h300;
        cycle();
        k_gnt = 1'b0; k_flush = 1'b1;
        cycle();
        k_flush = 1'b0;
        repeat (4) begin
            cycle();
            check("t4_req_low", 64'(s_req), 64'(0));
        end
        cycle();
        check("t4_req_again", 64'(s_req), 64'(1));
        check("t4_addr", 64'(s_addr), 64'h300);
        check("t4_empty", 64'(s_valid), 64'(0));

        // Flush in the same cycle as the grant.
        pc_reg = 32'h500;
        do_reset();
        k_gnt = 1'b1; k_ready = 1'b1; k_lat = 1; k_flush = 1'b1; k_target = 32'h600;
        cycle();
        check("t5_req", 64'(s_req), 64'(1));
        check("t5_pc_en_flush", 64'(s_pc_en), 64'(0));
        k_flush = 1'b0; k_gnt = 1'b0;
        cycle();
        check("t5_drop_req", 64'(s_req), 64'(0));
        cycle();
        check("t5_idle_req", 64'(s_req), 64'(0));
        cycle();
        check("t5_req_again", 64'(s_req), 64'(1));
        check("t5_addr", 64'(s_addr), 64'h600);

        // Flush coinciding with a pop on a full buffer.
        pc_reg = 32'h0;
        do_reset();
        k_gnt = 1'b1; k_ready = 1'b0; k_lat = 1;
        repeat (5) cycle();
        check("t5b_fetches", 64'(n_pc_en), 64'(2));
        k_gnt = 1'b0; k_ready = 1'b1; k_flush = 1'b1; k_target = 32'h40;
        cycle();
        k_flush = 1'b0;
        cycle();
        check("t5b_flushed", 64'(s_valid), 64'(0));

        // Asynchronous reset while waiting for data; the stale return is ignored.
        pc_reg = 32'h200;
        do_reset();
        k_gnt = 1'b1; k_ready = 1'b0; k_lat = 1; k_fixed = 1'b1; k_data = 32'h1234_5678;
        cycle();
        cycle();
        k_lat = 3;
        cycle();
        cycle();
        #3;
        check("t6_pre_valid", 64'(instr_valid_o), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t6_req", 64'(imem_req_o), 64'(0));
        check("t6_addr", 64'(imem_addr_o), 64'(0));
        check("t6_pc_en", 64'(pc_en_o), 64'(0));
        check("t6_valid", 64'(instr_valid_o), 64'(0));
        check("t6_instr", 64'(instr_o), 64'(0));
        check("t6_instr_pc", 64'(instr_pc_o), 64'(0));
        q.delete();
        pend_killed = 1'b1;
        pend_stale  = 1'b1;
        k_gnt       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle();
        check("t6_no_stale", 64'(s_valid), 64'(0));
        k_gnt = 1'b1; k_lat = 1; k_fixed = 1'b0;
        repeat (8) cycle();

        // Randomized traffic.
        pc_reg = $urandom;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            k_gnt    = ($urandom_range(0, 2) != 0);
            k_ready  = ($urandom_range(0, 3) != 0);
            k_flush  = ($urandom_range(0, 29) == 0);
            k_lat    = $urandom_range(1, 3);
            k_target = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
